// File: rtl/hero_write_rx.sv
// Receive end of the hero write bus: stages each transaction speculatively in a beat FIFO,
// releases it on its DONE beat, and discards malformed or unadmittable transactions whole.
module hero_write_rx #(
    parameter int HERO_WIDTH = 36,
    parameter int CT_W       = 2,
    parameter int MAX_BEATS  = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CT_W-1:0]       hero_cycle_type,
    input  logic [HERO_WIDTH-1:0] hero_wdat,
    input  logic                  hero_clk_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [HERO_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  err_overflow,
    output logic                  err_protocol,
    output logic                  txn_commit,
    output logic [15:0]           dropped_txns
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_BEATS + 1);

    localparam logic [CT_W-1:0] CT_IDLE  = CT_W'(0);
    localparam logic [CT_W-1:0] CT_DONE  = CT_W'(2);
    localparam logic [CT_W-1:0] CT_ILL   = CT_W'(3);
    localparam logic [PW-1:0]   DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0]   MAXB_P   = PW'(MAX_BEATS);
    localparam logic [CW-1:0]   MAXB_C   = CW'(MAX_BEATS);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

    state_t                r_state, w_state_nx;
    logic [PW-1:0]         r_rd, r_wr_commit, r_wr_spec;
    logic [PW-1:0]         w_commit_nx, w_spec_nx;
    logic [CW-1:0]         r_cnt, w_cnt_nx;
    logic [15:0]           r_dropped;
    logic                  r_err_ovf, r_err_prot, r_commit;
    logic [HERO_WIDTH:0]   r_mem [DEPTH];

    logic                  w_beat, w_is_done, w_is_ill, w_admit, w_we;
    logic                  w_ovf, w_prot, w_commit_p, w_drop_inc, w_valid, w_pop;
    logic [PW-1:0]         w_used;
    logic [HERO_WIDTH:0]   w_rd_entry;

    assign w_beat    = hero_clk_en && (hero_cycle_type != CT_IDLE);
    assign w_is_done = (hero_cycle_type == CT_DONE);
    assign w_is_ill  = (hero_cycle_type == CT_ILL);
    // Registered occupancy only; a same-cycle pop is deliberately not credited.
    assign w_used    = r_wr_spec - r_rd;
    assign w_admit   = (DEPTH_P - w_used) >= MAXB_P;

    always_comb begin
        w_state_nx  = r_state;
        w_spec_nx   = r_wr_spec;
        w_commit_nx = r_wr_commit;
        w_cnt_nx    = r_cnt;
        w_we        = 1'b0;
        w_ovf       = 1'b0;
        w_prot      = 1'b0;
        w_commit_p  = 1'b0;
        w_drop_inc  = 1'b0;
        if (w_beat) begin
            if (w_is_ill) begin
                w_spec_nx  = r_wr_commit;
                w_prot     = 1'b1;
                w_drop_inc = (r_state == S_RECV);
                w_cnt_nx   = '0;
                w_state_nx = S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_admit) begin
                            w_we       = 1'b1;
                            w_spec_nx  = r_wr_spec + PW'(1);
                            w_cnt_nx   = CW'(1);
                            if (w_is_done) begin
                                w_commit_nx = r_wr_spec + PW'(1);
                                w_commit_p  = 1'b1;
                            end else begin
                                w_state_nx = S_RECV;
                            end
                        end else begin
                            w_ovf      = 1'b1;
                            w_drop_inc = 1'b1;
                            w_state_nx = w_is_done ? S_IDLE : S_DROP;
                        end
                    end
                    S_RECV: begin
                        if (r_cnt == MAXB_C) begin
                            w_spec_nx  = r_wr_commit;
                            w_prot     = 1'b1;
                            w_drop_inc = 1'b1;
                            w_cnt_nx   = '0;
                            w_state_nx = w_is_done ? S_IDLE : S_DROP;
                        end else begin
                            w_we      = 1'b1;
                            w_spec_nx = r_wr_spec + PW'(1);
                            w_cnt_nx  = r_cnt + CW'(1);
                            if (w_is_done) begin
                                w_commit_nx = r_wr_spec + PW'(1);
                                w_commit_p  = 1'b1;
                                w_state_nx  = S_IDLE;
                            end
                        end
                    end
                    S_DROP: begin
                        if (w_is_done) w_state_nx = S_IDLE;
                    end
                    default: w_state_nx = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rd        <= '0;
            r_wr_commit <= '0;
            r_wr_spec   <= '0;
            r_cnt       <= '0;
            r_dropped   <= '0;
            r_err_ovf   <= 1'b0;
            r_err_prot  <= 1'b0;
            r_commit    <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_wr_spec   <= w_spec_nx;
            r_wr_commit <= w_commit_nx;
            r_cnt       <= w_cnt_nx;
            r_err_ovf   <= w_ovf;
            r_err_prot  <= w_prot;
            r_commit    <= w_commit_p;
            if (w_pop) r_rd <= r_rd + PW'(1);
            if (w_drop_inc && (r_dropped != 16'hFFFF)) r_dropped <= r_dropped + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr_spec[AW-1:0]] <= {w_is_done, hero_wdat};
    end

    assign w_valid    = (r_rd != r_wr_commit);
    assign w_pop      = w_valid && out_ready;
    assign w_rd_entry = r_mem[r_rd[AW-1:0]];

    // Data is masked while nothing is committed so stale entries never leak out.
    assign out_valid    = w_valid;
    assign out_data     = w_valid ? w_rd_entry[HERO_WIDTH-1:0] : '0;
    assign out_last     = w_valid && w_rd_entry[HERO_WIDTH];
    assign err_overflow = r_err_ovf;
    assign err_protocol = r_err_prot;
    assign txn_commit   = r_commit;
    assign dropped_txns = r_dropped;

endmodule
